// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode encodings: opcodes, ALU operations, result and immediate selects.
package decode_stage_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  // funct3 map shared by R and I types; unlisted funct3 values fall back to add.
  function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  alu_decode = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_decode = ALU_AND;
      3'b110:  alu_decode = ALU_OR;
      3'b100:  alu_decode = ALU_XOR;
      3'b010:  alu_decode = ALU_SLT;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] imm_extend(input logic [31:0] instr, input imm_src_t src);
    case (src)
      IMM_I:   imm_extend = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_extend = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_extend = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_extend = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, write-first bypass, synchronous clear.
module register_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // A write landing this cycle is visible to readers before the edge.
  always_comb begin
    if (ra1 == '0)                rd1 = '0;
    else if (we && wa == ra1)     rd1 = wd;
    else                          rd1 = regs[ra1];
    if (ra2 == '0)                rd2 = '0;
    else if (we && wa == ra2)     rd2 = wd;
    else                          rd2 = regs[ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate extension, register file
// and the decode->execute pipeline register with flush-to-bubble.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [31:0]     ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  opcode_t         op;
  logic            reg_write;
  logic            alu_src;
  logic            mem_write;
  logic            jump;
  logic            branch;
  result_src_t     result_src;
  alu_ctrl_t       alu_ctrl;
  imm_src_t        imm_src;
  logic [31:0]     imm_ext;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_register_file (
    .clk (clk),
    .rst (rst),
    .ra1 (InstrD[19:15]),
    .ra2 (InstrD[24:20]),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW)
  );

  assign op = opcode_t'(InstrD[6:0]);

  always_comb begin
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    result_src = RES_ALU;
    alu_ctrl   = ALU_ADD;
    imm_src    = IMM_I;
    case (op)
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_ctrl  = alu_decode(InstrD[14:12], InstrD[30]);
      end
      // funct7[5] is immediate data for I-type, so subtract is never selected.
      OP_ITYPE: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = alu_decode(InstrD[14:12], 1'b0);
      end
      OP_BRANCH: begin
        branch   = 1'b1;
        alu_ctrl = ALU_SUB;
        imm_src  = IMM_B;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
      end
      default: ;
    endcase
  end

  assign imm_ext = imm_extend(InstrD, imm_src);

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write;
      ALUSrcE     <= alu_src;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_ctrl;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      Rs1E        <= InstrD[19:15];
      Rs2E        <= InstrD[24:20];
      RdE         <= InstrD[11:7];
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule
